// File: rtl/alarm_pkg.sv
// Shared encodings for the alarm controller: 3-bit FSM state codes, arming modes
// and the timer width helper.
package alarm_pkg;

  localparam logic [2:0] DISARMED = 3'd0;
  localparam logic [2:0] EXIT     = 3'd1;
  localparam logic [2:0] ARMED    = 3'd2;
  localparam logic [2:0] ENTRY    = 3'd3;
  localparam logic [2:0] ALARM    = 3'd4;

  localparam logic AWAY = 1'b0;
  localparam logic STAY = 1'b1;

  // A width of at least 1 bit keeps the counter legal when both delays are 1.
  function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Panel/sensor bundle between the keypad side (master) and the controller (slave).
interface alarm_ctrl_if #(
  parameter int unsigned N_DOORS   = 2,
  parameter int unsigned N_WINDOWS = 3
);
  logic                 arm_away;
  logic                 arm_stay;
  logic                 disarm;
  logic [N_DOORS-1:0]   doors;
  logic [N_WINDOWS-1:0] windows;
  logic                 secure;
  logic                 armed;
  logic                 pending;
  logic                 alarm;
  logic                 chime;

  modport master (
    output arm_away, arm_stay, disarm, doors, windows,
    input  secure, armed, pending, alarm, chime
  );

  modport slave (
    input  arm_away, arm_stay, disarm, doors, windows,
    output secure, armed, pending, alarm, chime
  );
endinterface

// File: rtl/alarm_timer.sv
// Loadable down-counter shared by the exit and entry delays; holds at zero.
module alarm_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/alarm_ctrl.sv
// Intrusion alarm controller: away/stay arming with exit and entry delays.
// Optional door chime in DISARMED is built only when ALARM_CHIME_EN is defined.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned N_DOORS   = 2,
  parameter int unsigned N_WINDOWS = 3,
  parameter int unsigned EXIT_DLY  = 8,
  parameter int unsigned ENTRY_DLY = 4
) (
  input logic         clk,
  input logic         reset,
  alarm_ctrl_if.slave bus
);
  localparam int unsigned    TW       = tmr_width(EXIT_DLY, ENTRY_DLY);
  localparam logic [TW-1:0]  EXIT_LD  = TW'(EXIT_DLY - 1);
  localparam logic [TW-1:0]  ENTRY_LD = TW'(ENTRY_DLY - 1);

  logic [2:0]    state, state_nxt;
  logic          mode, mode_nxt;
  logic          tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic          door_open, win_open, secure;

  assign door_open = |bus.doors;
  assign win_open  = |bus.windows;
  assign secure    = ~door_open & ~win_open;

  alarm_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    tmr_load  = 1'b0;
    tmr_val   = EXIT_LD;
    tmr_dec   = 1'b0;
    if (bus.disarm) begin
      state_nxt = DISARMED;
    end else begin
      case (state)
        DISARMED: begin
          if (secure && bus.arm_away) begin
            state_nxt = EXIT;
            mode_nxt  = AWAY;
            tmr_load  = 1'b1;
            tmr_val   = EXIT_LD;
          end else if (secure && bus.arm_stay) begin
            state_nxt = ARMED;
            mode_nxt  = STAY;
          end
        end
        EXIT: begin
          if (tmr_zero) state_nxt = secure ? ARMED : ALARM;
          else          tmr_dec   = 1'b1;
        end
        ARMED: begin
          if (mode == STAY) begin
            if (!secure) state_nxt = ALARM;
          end else if (win_open) begin
            state_nxt = ALARM;
          end else if (door_open) begin
            state_nxt = ENTRY;
            tmr_load  = 1'b1;
            tmr_val   = ENTRY_LD;
          end
        end
        ENTRY: begin
          if (win_open || tmr_zero) state_nxt = ALARM;
          else                      tmr_dec   = 1'b1;
        end
        ALARM:   state_nxt = ALARM;
        default: state_nxt = DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DISARMED;
      mode  <= AWAY;
    end else begin
      state <= state_nxt;
      mode  <= mode_nxt;
    end
  end

  assign bus.secure  = secure;
  assign bus.armed   = (state == ARMED) || (state == ENTRY);
  assign bus.pending = (state == EXIT)  || (state == ENTRY);
  assign bus.alarm   = (state == ALARM);

`ifdef ALARM_CHIME_EN
  logic [N_DOORS-1:0] doors_q;
  logic               chime_q;

  // Rising-edge detect on the door bits, gated by the state at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      doors_q <= '0;
      chime_q <= 1'b0;
    end else begin
      doors_q <= bus.doors;
      chime_q <= (state == DISARMED) && (|(bus.doors & ~doors_q));
    end
  end

  assign bus.chime = chime_q;
`else
  assign bus.chime = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed scoreboard bench for alarm_ctrl at default parameters.
module tb_alarm_ctrl;
  logic clk = 1'b0;
  logic reset;

  alarm_ctrl_if #(.N_DOORS(2), .N_WINDOWS(3)) bus ();

  alarm_ctrl #(
    .N_DOORS   (2),
    .N_WINDOWS (3),
    .EXIT_DLY  (8),
    .ENTRY_DLY (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef ALARM_CHIME_EN
  localparam bit CHIME_ON = 1'b1;
`else
  localparam bit CHIME_ON = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [4:0] outs;   // {armed, pending, alarm, secure, chime}
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check_out();
    exp_t       e;
    logic [4:0] obs;
    e   = sb.pop_front();
    obs = {bus.armed, bus.pending, bus.alarm, bus.secure, bus.chime};
    vectors++;
    assert (obs === e.outs) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (armed,pending,alarm,secure,chime)",
             e.tag, obs, e.outs);
    end
  endtask

  // Drive one cycle of inputs, queue what the outputs must be after the edge,
  // then sample 1 time unit past the edge.
  task automatic step(input string tag, input logic rst, input logic aa, input logic as,
                      input logic ds, input logic [1:0] d, input logic [2:0] w,
                      input logic ea, input logic ep, input logic eal, input logic ech);
    exp_t e;
    reset        = rst;
    bus.arm_away = aa;
    bus.arm_stay = as;
    bus.disarm   = ds;
    bus.doors    = d;
    bus.windows  = w;
    e.tag  = tag;
    e.outs = {ea, ep, eal, (d == 2'b00) && (w == 3'b000), ech & CHIME_ON};
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step("reset",         1, 0,0,0, 2'b00, 3'b000, 0,0,0,0);
    step("idle",          0, 0,0,0, 2'b00, 3'b000, 0,0,0,0);

    // Away arming: 8 cycles of exit delay, then entry delay of 4, then alarm.
    step("away_arm",      0, 1,0,0, 2'b00, 3'b000, 0,1,0,0);
    for (int i = 0; i < 7; i++)
      step($sformatf("exit_run%0d", i), 0, 0,0,0, 2'b00, 3'b000, 0,1,0,0);
    step("exit_done",     0, 0,0,0, 2'b00, 3'b000, 1,0,0,0);
    step("entry_start",   0, 0,0,0, 2'b01, 3'b000, 1,1,0,0);
    for (int i = 0; i < 3; i++)
      step($sformatf("entry_run%0d", i), 0, 0,0,0, 2'b01, 3'b000, 1,1,0,0);
    step("entry_expire",  0, 0,0,0, 2'b01, 3'b000, 0,0,1,0);
    step("alarm_disarm",  0, 0,0,1, 2'b00, 3'b000, 0,0,0,0);

    // Stay arming: immediate, window trips alarm, alarm latches.
    step("stay_arm",      0, 0,1,0, 2'b00, 3'b000, 1,0,0,0);
    step("stay_window",   0, 0,0,0, 2'b00, 3'b100, 0,0,1,0);
    step("alarm_latch",   0, 0,0,0, 2'b00, 3'b000, 0,0,1,0);
    step("alarm_hold",    0, 0,0,0, 2'b00, 3'b000, 0,0,1,0);
    step("stay_disarm",   0, 0,0,1, 2'b00, 3'b000, 0,0,0,0);

    // Arming refused while insecure; chime on door opening in DISARMED.
    step("door_chime",    0, 0,0,0, 2'b01, 3'b000, 0,0,0,1);
    step("arm_insecure",  0, 1,0,0, 2'b01, 3'b000, 0,0,0,0);
    step("stay_insecure", 0, 0,1,0, 2'b00, 3'b010, 0,0,0,0);
    step("close_all",     0, 0,0,0, 2'b00, 3'b000, 0,0,0,0);

    // Door opened and closed during exit is ignored; disarm in 2nd entry cycle.
    step("away_arm2",     0, 1,0,0, 2'b00, 3'b000, 0,1,0,0);
    for (int i = 0; i < 7; i++)
      step($sformatf("exit2_run%0d", i), 0, 0,0,0,
           (i >= 1 && i <= 3) ? 2'b10 : 2'b00, 3'b000, 0,1,0,0);
    step("exit2_done",    0, 0,0,0, 2'b00, 3'b000, 1,0,0,0);
    step("entry2_start",  0, 0,0,0, 2'b10, 3'b000, 1,1,0,0);
    step("entry2_disarm", 0, 0,0,1, 2'b10, 3'b000, 0,0,0,0);
    step("entry2_close",  0, 0,0,0, 2'b00, 3'b000, 0,0,0,0);

    // Door still open on the final exit edge -> alarm; reset clears alarm.
    step("away_arm3",     0, 1,0,0, 2'b00, 3'b000, 0,1,0,0);
    for (int i = 0; i < 7; i++)
      step($sformatf("exit3_run%0d", i), 0, 0,0,0, 2'b00, 3'b000, 0,1,0,0);
    step("exit_insecure", 0, 0,0,0, 2'b01, 3'b000, 0,0,1,0);
    step("reset_in_alarm",1, 0,0,0, 2'b01, 3'b000, 0,0,0,0);
    step("post_reset1",   0, 0,0,0, 2'b00, 3'b000, 0,0,0,0);

    // Reset mid-exit.
    step("away_arm4",     0, 1,0,0, 2'b00, 3'b000, 0,1,0,0);
    for (int i = 0; i < 3; i++)
      step($sformatf("exit4_run%0d", i), 0, 0,0,0, 2'b00, 3'b000, 0,1,0,0);
    step("reset_mid_exit",1, 1,0,0, 2'b00, 3'b000, 0,0,0,0);
    step("post_reset2",   0, 0,0,0, 2'b00, 3'b000, 0,0,0,0);

    // Request priorities.
    step("both_arm",      0, 1,1,0, 2'b00, 3'b000, 0,1,0,0);
    step("disarm_exit",   0, 0,0,1, 2'b00, 3'b000, 0,0,0,0);
    step("disarm_and_arm",0, 1,0,1, 2'b00, 3'b000, 0,0,0,0);
    step("stay_arm2",     0, 0,1,0, 2'b00, 3'b000, 1,0,0,0);
    step("disarm_beats_arm", 0, 1,0,1, 2'b00, 3'b000, 0,0,0,0);

    // Stay mode: door open is an immediate alarm, no entry delay.
    step("stay_arm3",     0, 0,1,0, 2'b00, 3'b000, 1,0,0,0);
    step("stay_door",     0, 0,0,0, 2'b01, 3'b000, 0,0,1,0);
    step("stay_door_dis", 0, 0,0,1, 2'b00, 3'b000, 0,0,0,0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
